stripe_scheduler: RTL

STRIPE_SCHEDULER -- requirements
Module: stripe_scheduler

---
 rtl/stripe_scheduler.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/stripe_scheduler.sv
// Stripes a symbol stream into 4-lane rows and periodically inserts COM/SKP
// ordered-set rows between packets.
module stripe_scheduler #(
    parameter int unsigned SKP_INTERVAL = 16
) (
    input  logic       CLK,
    input  logic       RESET_L,
    input  logic [7:0] D,
    input  logic       DK,
    input  logic       IN_VALID,
    output logic       IN_READY,
    output logic [7:0] LANE0,
    output logic [7:0] LANE1,
    output logic [7:0] LANE2,
    output logic [7:0] LANE3,
    output logic       DK_0,
    output logic       DK_1,
    output logic       DK_2,
    output logic       DK_3,
    output logic       OUT_VALID,
    output logic       ERR
);
    localparam logic [7:0] K_STP   = 8'hFB;
    localparam logic [7:0] K_SDP   = 8'h5C;
    localparam logic [7:0] K_END   = 8'hFD;
    localparam logic [7:0] K_EDB   = 8'hFE;
    localparam logic [7:0] K_COM   = 8'hBC;
    localparam logic [7:0] K_SKP   = 8'h1C;
    localparam logic [7:0] K_IDL   = 8'h7C;
    localparam logic [7:0] SKP_MAX = 8'(SKP_INTERVAL);

    typedef enum logic [1:0] {S_IDLE, S_PKT, S_SKP_COM, S_SKP_SKP} state_e;

    state_e     state_q, state_d;
    logic [1:0] lane_q, lane_d;
    logic [7:0] row_cnt_q, row_cnt_d;
    logic       skp_pend_q, skp_pend_d;
    logic [7:0] hold_q [4];
    logic [7:0] hold_d [4];
    logic [3:0] hold_k_q, hold_k_d;
    logic [7:0] row_q [4];
    logic [7:0] row_d [4];
    logic [3:0] row_k_q, row_k_d;
    logic       out_valid_q, out_valid_d;
    logic       err_q, err_d;
    logic       accept, is_start, is_end, data_row;

    assign IN_READY = (state_q == S_PKT) || ((state_q == S_IDLE) && !skp_pend_q);
    assign accept   = IN_VALID && IN_READY;
    assign is_start = DK && ((D == K_STP) || (D == K_SDP));
    assign is_end   = DK && ((D == K_END) || (D == K_EDB));

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        row_cnt_d   = row_cnt_q;
        skp_pend_d  = skp_pend_q;
        hold_d      = hold_q;
        hold_k_d    = hold_k_q;
        row_d       = row_q;
        row_k_d     = row_k_q;
        out_valid_d = 1'b0;
        err_d       = 1'b0;
        data_row    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (skp_pend_q) begin
                    state_d = S_SKP_COM;
                end else if (accept) begin
                    if (is_start) begin
                        hold_d[0]   = D;
                        hold_k_d[0] = DK;
                        lane_d      = 2'd1;
                        state_d     = S_PKT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PKT: begin
                if (accept) begin
                    if (is_start) begin
                        // Restart: flush any partial row padded with IDL, new start goes to lane 0.
                        err_d = 1'b1;
                        if (lane_q != 2'd0) begin
                            for (int unsigned i = 0; i < 4; i++) begin
                                row_d[i]   = (2'(i) < lane_q) ? hold_q[i] : K_IDL;
                                row_k_d[i] = (2'(i) < lane_q) ? hold_k_q[i] : 1'b1;
                            end
                            out_valid_d = 1'b1;
                            data_row    = 1'b1;
                        end
                        hold_d[0]   = D;
                        hold_k_d[0] = DK;
                        lane_d      = 2'd1;
                    end else if (is_end || (lane_q == 2'd3)) begin
                        for (int unsigned i = 0; i < 4; i++) begin
                            if (2'(i) < lane_q) begin
                                row_d[i]   = hold_q[i];
                                row_k_d[i] = hold_k_q[i];
                            end else if (2'(i) == lane_q) begin
                                row_d[i]   = D;
                                row_k_d[i] = DK;
                            end else begin
                                row_d[i]   = K_IDL;
                                row_k_d[i] = 1'b1;
                            end
                        end
                        out_valid_d = 1'b1;
                        data_row    = 1'b1;
                        lane_d      = 2'd0;
                        if (is_end) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        hold_d[lane_q]   = D;
                        hold_k_d[lane_q] = DK;
                        lane_d           = lane_q + 2'd1;
                    end
                end
            end
            S_SKP_COM: begin
                row_d       = '{K_COM, K_COM, K_COM, K_COM};
                row_k_d     = '1;
                out_valid_d = 1'b1;
                state_d     = S_SKP_SKP;
            end
            default: begin
                row_d       = '{K_SKP, K_SKP, K_SKP, K_SKP};
                row_k_d     = '1;
                out_valid_d = 1'b1;
                row_cnt_d   = '0;
                skp_pend_d  = 1'b0;
                state_d     = S_IDLE;
            end
        endcase

        if (data_row) begin
            row_cnt_d = (row_cnt_q >= SKP_MAX) ? row_cnt_q : row_cnt_q + 8'd1;
            if (row_cnt_d == SKP_MAX) begin
                skp_pend_d = 1'b1;
            end
        end

        // Going straight to SKP_COM lets the COM row follow the final data row back-to-back.
        if ((state_d == S_IDLE) && skp_pend_d) begin
            state_d = S_SKP_COM;
        end
    end

    always_ff @(posedge CLK or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q     <= S_IDLE;
            lane_q      <= '0;
            row_cnt_q   <= '0;
            skp_pend_q  <= 1'b0;
            hold_q      <= '{default: '0};
            hold_k_q    <= '0;
            row_q       <= '{default: '0};
            row_k_q     <= '0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            row_cnt_q   <= row_cnt_d;
            skp_pend_q  <= skp_pend_d;
            hold_q      <= hold_d;
            hold_k_q    <= hold_k_d;
            row_q       <= row_d;
            row_k_q     <= row_k_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign LANE0     = row_q[0];
    assign LANE1     = row_q[1];
    assign LANE2     = row_q[2];
    assign LANE3     = row_q[3];
    assign DK_0      = row_k_q[0];
    assign DK_1      = row_k_q[1];
    assign DK_2      = row_k_q[2];
    assign DK_3      = row_k_q[3];
    assign OUT_VALID = out_valid_q;
    assign ERR       = err_q;

endmodule
